// File: rtl/display_scanout_if.sv
// Scanout bus: the pixel-buffer read port plus the video timing/colour outputs.
// The scanout engine is the master. The buffer and video sink side is the slave.
interface display_scanout_if;
    logic [13:0] address;
    logic [11:0] read_data;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        display_on;
    logic        frame_start;

    modport master (
        output address,
        input  read_data,
        output red,
        output green,
        output blue,
        output hsync,
        output vsync,
        output display_on,
        output frame_start
    );

    modport slave (
        input  address,
        output read_data,
        input  red,
        input  green,
        input  blue,
        input  hsync,
        input  vsync,
        input  display_on,
        input  frame_start
    );
endinterface

// File: rtl/display_scanout.sv
// Raster scanout engine.
// Free-running h/v counters drive a combinational buffer read address.
// A two-stage pipeline lines up the one-cycle buffer latency with the timing flags.
// As a result, colour, sync, display_on and frame_start all trail the counters by
// exactly two clocks.
module display_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 128,
    parameter int IMG_H    = 128
) (
    input  logic               clk,
    input  logic               reset,
    display_scanout_if.master  bus
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW      = $clog2(H_TOTAL);
    localparam int VCW      = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);

    // Stage 0: raster position
    logic [HCW-1:0] r_h;
    logic [VCW-1:0] r_v;

    // Stage-0 decode
    logic w_active;
    logic w_in_img;
    logic w_hsync_n;
    logic w_vsync_n;
    logic w_frame_start;

    // Stage 1: flags of the pixel whose buffer read is in flight
    logic r_s1_active;
    logic r_s1_in_img;
    logic r_s1_hsync_n;
    logic r_s1_vsync_n;
    logic r_s1_frame_start;

    // Stage 2: registered video outputs
    logic [11:0] r_rgb;
    logic        r_hsync_n;
    logic        r_vsync_n;
    logic        r_display_on;
    logic        r_frame_start;

    // Advance h every clock; on h wrap, advance v, and wrap v at the end of the frame.
    // NOTE: an asynchronous reset clears the state immediately, so a frame
    // interrupted by reset never finishes a sync pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + VCW'(1);
        end else begin
            r_h <= r_h + HCW'(1);
        end
    end

    // Decode the current raster position into region flags and the buffer address.
    // vsync edges fall on the hsync start column, so the vsync pulse spans a
    // whole number of line periods offset by HS_START.
    always_comb begin
        w_active      = (int'(r_h) < H_ACTIVE) && (int'(r_v) < V_ACTIVE);
        w_in_img      = (int'(r_h) < IMG_W) && (int'(r_v) < IMG_H);
        w_hsync_n     = !((int'(r_h) >= HS_START) && (int'(r_h) < HS_END));
        w_vsync_n     = 1'b1;
        if ((int'(r_v) == VS_START) && (int'(r_h) >= HS_START))
            w_vsync_n = 1'b0;
        else if ((int'(r_v) > VS_START) && (int'(r_v) < VS_END))
            w_vsync_n = 1'b0;
        else if ((int'(r_v) == VS_END) && (int'(r_h) < HS_START))
            w_vsync_n = 1'b0;
        w_frame_start = (r_h == '0) && (r_v == '0);
    end

    // Inside the image, the position maps directly to v*IMG_W+h. Outside it reads word 0.
    assign bus.address = w_in_img ? 14'(int'(r_v) * IMG_W + int'(r_h)) : 14'd0;

    // Hold the stage-0 flags while the buffer fetches the pixel.
    // NOTE: sequential state uses non-blocking assignments only, so every stage
    // samples the previous stage's value from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_active      <= 1'b0;
            r_s1_in_img      <= 1'b0;
            r_s1_hsync_n     <= 1'b1;
            r_s1_vsync_n     <= 1'b1;
            r_s1_frame_start <= 1'b0;
        end else begin
            r_s1_active      <= w_active;
            r_s1_in_img      <= w_in_img;
            r_s1_hsync_n     <= w_hsync_n;
            r_s1_vsync_n     <= w_vsync_n;
            r_s1_frame_start <= w_frame_start;
        end
    end

    // Register the buffer pixel for in-image positions and black for all others,
    // together with the matching stage-1 flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb         <= 12'h000;
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_display_on  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= r_s1_in_img ? bus.read_data : 12'h000;
            r_hsync_n     <= r_s1_hsync_n;
            r_vsync_n     <= r_s1_vsync_n;
            r_display_on  <= r_s1_active;
            r_frame_start <= r_s1_frame_start;
        end
    end

    assign bus.red         = r_rgb[11:8];
    assign bus.green       = r_rgb[7:4];
    assign bus.blue        = r_rgb[3:0];
    assign bus.hsync       = r_hsync_n;
    assign bus.vsync       = r_vsync_n;
    assign bus.display_on  = r_display_on;
    assign bus.frame_start = r_frame_start;

endmodule

// File: doc/display_scanout.md
DISPLAY_SCANOUT -- requirements
Module: display_scanout

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 Parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10; V_SYNC, default 2; V_BP, default 33; vertical porches and sync width, all in lines.
REQ-007 Parameter IMG_W, default 128, and IMG_H, default 128; image size in pixels, powers of two, IMG_W*IMG_H <= 16384, IMG_W <= H_ACTIVE, IMG_H <= V_ACTIVE.
REQ-008 Port clk, input, 1, pixel clock; the block uses one clock only.
REQ-009 Port reset, input, 1, asynchronous, active-high reset.
REQ-010 Port address, output, 14, pixel buffer read address.
REQ-011 Port read_data, input, 12, buffer pixel {R[11:8],G[7:4],B[3:0]}, valid the cycle after address is sampled.
REQ-012 Port red, green, blue, output, 4 each, pixel colour.
REQ-013 Port hsync, vsync, output, 1 each, active-low sync.
REQ-014 Port display_on, output, 1, high while red/green/blue carry a visible pixel.
REQ-015 Port frame_start, output, 1, one-cycle pulse marking pixel (0,0).

Function
REQ-016 Horizontal counter h SHALL count 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP), then wrap to 0 and increment v.
REQ-017 Vertical counter v SHALL count 0..V_TOTAL-1 (V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP), advancing only when h wraps, and wrap to 0 when h and v both wrap.
REQ-018 Region order per axis SHALL be active, front porch, sync, back porch; h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] is horizontal sync, and likewise for v.
REQ-019 Stage 0 (cycle t): address SHALL be combinational from counters: {v mod IMG_H, h mod IMG_W} packed as v*IMG_W+h when h<IMG_W and v<IMG_H, else 14'd0.
REQ-020 Stage 1 (cycle t+1): the buffer presents read_data; active flags and sync flags of cycle t SHALL be held in a stage-1 register.
REQ-021 Stage 2: at the edge ending cycle t+1, outputs SHALL register read_data when pixel t was inside the image, else 12'h000.
REQ-022 Total latency from counter value to red/green/blue/hsync/vsync/display_on/frame_start SHALL be exactly 2 clocks for every output, so that all outputs stay aligned.
REQ-023 display_on SHALL be high iff h<H_ACTIVE and v<V_ACTIVE, delayed by the 2-clock pipeline.
REQ-024 Visible pixels outside the image (h>=IMG_W or v>=IMG_H) SHALL output black, with display_on high.
REQ-025 Blanking pixels SHALL output black regardless of read_data.
REQ-026 frame_start SHALL be high for exactly one clock per frame, 2 clocks after the counters reach (0,0).
REQ-027 hsync SHALL be low for exactly H_SYNC clocks per line; vsync SHALL be low for exactly V_SYNC*H_TOTAL clocks per frame, with edges aligned to h=H_ACTIVE+H_FP in the stage-0 domain.
REQ-028 The block SHALL never stall; read_data received while the buffer is busy writing is displayed as-is.

Reset
REQ-029 While reset is high, h=0, v=0, and all pipeline registers SHALL clear asynchronously: address=0, red=green=blue=0, hsync=1, vsync=1, display_on=0, frame_start=0.
REQ-030 On the first edge after reset deasserts, counters SHALL advance from (0,0); frame_start SHALL pulse 2 clocks after that first counted cycle at (0,0).
REQ-031 Reset asserted mid-frame SHALL abandon the frame immediately, with no partial sync pulse completed.

Verification
REQ-032 Small timing (H 8/2/2/2, V 4/1/1/1, IMG 4x2), free run -> H_TOTAL=14, V_TOTAL=7; frame_start period 98 clocks; hsync low 2 of every 14 clocks.
REQ-033 Buffer model returning read_data=address one cycle late -> pixel (h=3,v=1) outputs {r,g,b}=12'h007, 2 clocks after counters reach it; (h=5,v=1) outputs 0 with display_on=1.
REQ-034 Default parameters -> address 14'h3FFF at (127,127); address 0 at (128,0); 800*525=420000 clocks between frame_start pulses.
REQ-035 read_data forced to 12'hFFF -> RGB=0 whenever display_on=0, and never nonzero in porch or sync regions.
REQ-036 Reset pulsed at h=5,v=3 -> outputs go to reset values within the same cycle; hsync/vsync=1; counters restart at (0,0).
REQ-037 Line wrap at h=H_TOTAL-1, v=V_TOTAL-1 -> next counters (0,0), no skipped or duplicated line, vsync low for exactly V_SYNC lines.
